branch_resolve_bht: RTL

- Next-generation branch unit for the 5-stage RV32 pipeline.
- Resolves conditional branches in EX with XLEN-wide compares and registers the outcome for one cycle. Compares the outcome against the fetch-time prediction and raises mispredict for the redirect logic.
- Trains a direct-mapped table of 2-bit saturating counters, read combinationally by IF to produce the next prediction.

---
 rtl/branch_resolve_bht_pkg.sv | 27 ++
 rtl/branch_resolve_bht_if.sv | 37 +++
 rtl/branch_resolve_bht_sat_counter2.sv | 21 ++
 rtl/branch_resolve_bht.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_bht_pkg.sv
// Shared constants and types for the EX-stage branch resolver and its BHT.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
package branch_resolve_bht_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] FNC_BEQ  = 3'b000;
    localparam logic [2:0] FNC_BNE  = 3'b001;
    localparam logic [2:0] FNC_BLT  = 3'b100;
    localparam logic [2:0] FNC_BGE  = 3'b101;
    localparam logic [2:0] FNC_BLTU = 3'b110;
    localparam logic [2:0] FNC_BGEU = 3'b111;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_ctr_e;

    localparam bht_ctr_e BHT_RESET = BHT_WNT;

    function automatic logic ctr_predicts_taken(input bht_ctr_e ctr);
        return (ctr == BHT_WT) || (ctr == BHT_ST);
    endfunction

endpackage

// File: rtl/branch_resolve_bht_if.sv
// Fetch-lookup, EX-issue and resolve-result signals of the branch unit.
interface branch_resolve_bht_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] if_pc;
    logic            if_pred_taken;

    logic            ex_valid;
    logic            ex_stall;
    logic            ex_flush;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_a;
    logic [XLEN-1:0] ex_b;
    logic [XLEN-1:0] ex_pc;
    logic            ex_pred_taken;

    logic            res_valid;
    logic            res_taken;
    logic            res_mispredict;
    logic            res_illegal;
    logic [XLEN-1:0] res_pc;

    modport master (
        output if_pc, ex_valid, ex_stall, ex_flush, ex_opcode, ex_funct3,
               ex_a, ex_b, ex_pc, ex_pred_taken,
        input  if_pred_taken, res_valid, res_taken, res_mispredict,
               res_illegal, res_pc
    );

    modport slave (
        input  if_pc, ex_valid, ex_stall, ex_flush, ex_opcode, ex_funct3,
               ex_a, ex_b, ex_pc, ex_pred_taken,
        output if_pred_taken, res_valid, res_taken, res_mispredict,
               res_illegal, res_pc
    );
endinterface

// File: rtl/branch_resolve_bht_sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
module sat_counter2
    import branch_resolve_bht_pkg::*;
(
    input  bht_ctr_e cur,
    input  logic     taken,
    output bht_ctr_e nxt
);

    always_comb begin
        nxt = cur;
        case (cur)
            BHT_SNT: nxt = taken ? BHT_WNT : BHT_SNT;
            BHT_WNT: nxt = taken ? BHT_WT  : BHT_SNT;
            BHT_WT:  nxt = taken ? BHT_ST  : BHT_WNT;
            BHT_ST:  nxt = taken ? BHT_ST  : BHT_WT;
            default: nxt = BHT_RESET;
        endcase
    end

endmodule

// File: rtl/branch_resolve_bht.sv
// EX-stage branch resolver with one-cycle result register and a 2-bit BHT.
// Define BRANCH_STATS_EN to add branch / mispredict statistics counters.
module branch_resolve_bht
    import branch_resolve_bht_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_resolve_bht_if.slave    bus
`ifdef BRANCH_STATS_EN
    ,
    input  logic                   stat_clr,
    output logic [31:0]            stat_branches,
    output logic [31:0]            stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic            fire;
    logic            taken_c;
    logic            illegal_c;
    logic            mispredict_c;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic            wr_en;
    bht_ctr_e        ctr_cur;
    bht_ctr_e        ctr_next;
    logic [BHT_DEPTH-1:0] wr_hit;

    logic            res_valid_q, res_valid_d;
    logic            res_taken_q, res_taken_d;
    logic            res_mispredict_q, res_mispredict_d;
    logic            res_illegal_q, res_illegal_d;
    logic [XLEN-1:0] res_pc_q, res_pc_d;

    bht_ctr_e        bht_q [BHT_DEPTH];
    bht_ctr_e        bht_d [BHT_DEPTH];

    assign fire = bus.ex_valid && !bus.ex_stall && !bus.ex_flush
               && (bus.ex_opcode == OPC_BRANCH);

    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        case (bus.ex_funct3)
            FNC_BEQ:  taken_c = (bus.ex_a == bus.ex_b);
            FNC_BNE:  taken_c = (bus.ex_a != bus.ex_b);
            FNC_BLT:  taken_c = ($signed(bus.ex_a) <  $signed(bus.ex_b));
            FNC_BGE:  taken_c = ($signed(bus.ex_a) >= $signed(bus.ex_b));
            FNC_BLTU: taken_c = (bus.ex_a <  bus.ex_b);
            FNC_BGEU: taken_c = (bus.ex_a >= bus.ex_b);
            default:  illegal_c = 1'b1;
        endcase
    end

    // Illegal branches resolve not-taken, so they mispredict exactly when predicted taken.
    assign mispredict_c = taken_c ^ bus.ex_pred_taken;

    always_comb begin
        res_valid_d      = fire;
        res_taken_d      = fire && taken_c;
        res_mispredict_d = fire && mispredict_c;
        res_illegal_d    = fire && illegal_c;
        res_pc_d         = fire ? bus.ex_pc : res_pc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid_q      <= 1'b0;
            res_taken_q      <= 1'b0;
            res_mispredict_q <= 1'b0;
            res_illegal_q    <= 1'b0;
            res_pc_q         <= '0;
        end else begin
            res_valid_q      <= res_valid_d;
            res_taken_q      <= res_taken_d;
            res_mispredict_q <= res_mispredict_d;
            res_illegal_q    <= res_illegal_d;
            res_pc_q         <= res_pc_d;
        end
    end

    assign wr_idx  = bus.ex_pc[IDX_W+1:2];
    assign rd_idx  = bus.if_pc[IDX_W+1:2];
    assign wr_en   = fire && !illegal_c;
    assign ctr_cur = bht_q[wr_idx];

    sat_counter2 u_sat_counter2 (
        .cur   (ctr_cur),
        .taken (taken_c),
        .nxt   (ctr_next)
    );

    generate
        for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_wr_hit
            assign wr_hit[gi] = wr_en && (wr_idx == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < BHT_DEPTH; i++) begin
            bht_d[i] = wr_hit[i] ? ctr_next : bht_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= BHT_RESET;
            end
        end else begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= bht_d[i];
            end
        end
    end

    // Lookup reads the registered table: a same-cycle write is not bypassed.
    assign bus.if_pred_taken  = ctr_predicts_taken(bht_q[rd_idx]);
    assign bus.res_valid      = res_valid_q;
    assign bus.res_taken      = res_taken_q;
    assign bus.res_mispredict = res_mispredict_q;
    assign bus.res_illegal    = res_illegal_q;
    assign bus.res_pc         = res_pc_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (stat_clr) begin
            stat_branches_d    = '0;
            stat_mispredicts_d = '0;
        end else if (fire) begin
            if (stat_branches_q != 32'hFFFF_FFFF) begin
                stat_branches_d = stat_branches_q + 32'd1;
            end
            if (mispredict_c && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
                stat_mispredicts_d = stat_mispredicts_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
